// File: rtl/soc_uart_controller_pkg.sv
// soc_uart_controller_pkg
// Shared definitions for the UART bring-up controller: command opcodes,
// UART FSM state encodings and the bit-period helper.
package soc_uart_controller_pkg;

    localparam logic [7:0] CMD_CLK_OFF = 8'h00;
    localparam logic [7:0] CMD_CLK_ON  = 8'h01;
    localparam logic [7:0] CMD_RST_ON  = 8'h02;
    localparam logic [7:0] CMD_RST_OFF = 8'h03;
    localparam logic [7:0] CMD_TX_SOC  = 8'h04;
    localparam logic [7:0] CMD_TX_CTRL = 8'h05;
    localparam logic [7:0] CMD_RX_EN   = 8'h06;
    localparam logic [7:0] CMD_RX_DIS  = 8'h07;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/soc_uart_controller_uart.sv
// ctrl_uart
// 8N1 UART receiver and transmitter, LSB first.
// Ports:
//   clk27, reset   clock and synchronous active-high reset
//   i_rx           serial input line
//   o_rx_valid     one-cycle pulse when a frame with a good stop bit arrives
//   o_rx_data      received byte, valid with o_rx_valid
//   i_tx_start     start a transmit of i_tx_data (accepted only when idle)
//   i_tx_data      byte to transmit
//   o_tx           serial output line (idle high)
//   o_tx_busy      transmitter not idle
//
// state    | meaning
// IDLE     | line idle, waiting for falling edge (RX) / start request (TX)
// START    | start bit; RX re-checks it at mid-bit
// DATA     | PAYLOAD_BITS data bits, LSB first
// STOP     | stop bit; RX discards the byte if it samples low
module ctrl_uart
    import soc_uart_controller_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 2812,
    parameter int PAYLOAD_BITS   = 8
) (
    input  logic                    clk27,
    input  logic                    reset,
    input  logic                    i_rx,
    output logic                    o_rx_valid,
    output logic [PAYLOAD_BITS-1:0] o_rx_data,
    input  logic                    i_tx_start,
    input  logic [PAYLOAD_BITS-1:0] i_tx_data,
    output logic                    o_tx,
    output logic                    o_tx_busy
);

    localparam int CW = $clog2(CYCLES_PER_BIT);
    localparam int BW = $clog2(PAYLOAD_BITS);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(PAYLOAD_BITS - 1);

    // ---------------- receiver ----------------
    rx_state_e               r_rx_state;
    rx_state_e               w_rx_next;
    logic                    r_rx_meta;
    logic                    r_rx_sync;
    logic                    r_rx_prev;
    logic [CW-1:0]           r_rx_cnt;
    logic [BW-1:0]           r_rx_bit;
    logic [PAYLOAD_BITS-1:0] r_rx_shift;
    logic                    r_rx_valid;
    logic [PAYLOAD_BITS-1:0] r_rx_data;
    logic                    w_rx_tc;

    assign w_rx_tc = (r_rx_cnt == '0);

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk27) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    always_ff @(posedge clk27) begin
        if (reset) r_rx_state <= RX_IDLE;
        else       r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_next = RX_START;
            RX_START: if (w_rx_tc) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tc && (r_rx_bit == LAST_BIT)) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_tc) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    // The first countdown after the edge is half a bit, so every later
    // reload of a full bit period lands on mid-bit.
    always_ff @(posedge clk27) begin
        if (reset) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= HALF_LOAD;
                    r_rx_bit <= '0;
                end
                RX_START: r_rx_cnt <= w_rx_tc ? BIT_LOAD : r_rx_cnt - 1'b1;
                RX_DATA: begin
                    if (w_rx_tc) begin
                        r_rx_cnt   <= BIT_LOAD;
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[PAYLOAD_BITS-1:1]};
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_rx_tc) begin
                        if (r_rx_sync) begin
                            r_rx_valid <= 1'b1;
                            r_rx_data  <= r_rx_shift;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                default: r_rx_cnt <= '0;
            endcase
        end
    end

    assign o_rx_valid = r_rx_valid;
    assign o_rx_data  = r_rx_data;

    // ---------------- transmitter ----------------
    tx_state_e               r_tx_state;
    tx_state_e               w_tx_next;
    logic [CW-1:0]           r_tx_cnt;
    logic [BW-1:0]           r_tx_bit;
    logic [PAYLOAD_BITS-1:0] r_tx_shift;
    logic                    w_tx_tc;

    assign w_tx_tc = (r_tx_cnt == '0);

    always_ff @(posedge clk27) begin
        if (reset) r_tx_state <= TX_IDLE;
        else       r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        o_tx      = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                if (i_tx_start) w_tx_next = TX_START;
            end
            TX_START: begin
                o_tx = 1'b0;
                if (w_tx_tc) w_tx_next = TX_DATA;
            end
            TX_DATA: begin
                o_tx = r_tx_shift[0];
                if (w_tx_tc && (r_tx_bit == LAST_BIT)) w_tx_next = TX_STOP;
            end
            TX_STOP: begin
                if (w_tx_tc) w_tx_next = TX_IDLE;
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk27) begin
        if (reset) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_cnt <= BIT_LOAD;
                    r_tx_bit <= '0;
                    if (i_tx_start) r_tx_shift <= i_tx_data;
                end
                TX_START: r_tx_cnt <= w_tx_tc ? BIT_LOAD : r_tx_cnt - 1'b1;
                TX_DATA: begin
                    if (w_tx_tc) begin
                        r_tx_cnt   <= BIT_LOAD;
                        r_tx_bit   <= r_tx_bit + 1'b1;
                        r_tx_shift <= r_tx_shift >> 1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 1'b1;
                    end
                end
                TX_STOP: r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= '0;
            endcase
        end
    end

    assign o_tx_busy = (r_tx_state != TX_IDLE);

endmodule

// File: rtl/soc_uart_controller.sv
// soc_uart_controller
// UART debug controller between the board pins and the SoC: decodes
// single-byte commands to gate the SoC clock, pulse the SoC reset and steer
// the UART pins; every received byte is echoed on the controller TX.
// Ports:
//   clk27, reset   clock and synchronous active-high controller reset
//   serial_rx/tx   board UART pins
//   led_n1         status LED, low while the SoC reset pulse is active
//   soc_tx/soc_rx  SoC UART pins
//   soc_clk        glitch-free gated clk27
//   soc_reset      active-high SoC reset
module soc_uart_controller
    import soc_uart_controller_pkg::*;
#(
    parameter int CLK_HZ       = 27000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int RESET_CYCLES = 50
) (
    input  logic clk27,
    input  logic reset,
    input  logic serial_rx,
    output logic serial_tx,
    output logic led_n1,
    input  logic soc_tx,
    output logic soc_rx,
    output logic soc_clk,
    output logic soc_reset
);

    localparam int         CPB         = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam logic [7:0] RESET_LIMIT = 8'(RESET_CYCLES);

    logic                    w_rx_valid;
    logic [PAYLOAD_BITS-1:0] w_rx_data;
    logic                    w_uart_tx;
    logic                    w_tx_busy;
    logic                    w_tx_start;

    logic       r_clk_enable;
    logic       r_soc_reset;
    logic       r_led;
    logic       r_output_sel;
    logic       r_input_sel;
    logic [7:0] r_counter;
    logic       r_clk_en_lat;

    // Echo only when the transmitter is free; otherwise the byte is dropped.
    assign w_tx_start = w_rx_valid && !w_tx_busy;

    ctrl_uart #(
        .CYCLES_PER_BIT (CPB),
        .PAYLOAD_BITS   (PAYLOAD_BITS)
    ) u_uart (
        .clk27      (clk27),
        .reset      (reset),
        .i_rx       (serial_rx),
        .o_rx_valid (w_rx_valid),
        .o_rx_data  (w_rx_data),
        .i_tx_start (w_tx_start),
        .i_tx_data  (w_rx_data),
        .o_tx       (w_uart_tx),
        .o_tx_busy  (w_tx_busy)
    );

    // Pulse counter first; a command decoded in the same cycle is written
    // last and therefore wins.
    always_ff @(posedge clk27) begin
        if (reset) begin
            r_clk_enable <= 1'b1;
            r_soc_reset  <= 1'b0;
            r_led        <= 1'b1;
            r_output_sel <= 1'b0;
            r_input_sel  <= 1'b0;
            r_counter    <= '0;
        end else begin
            if (r_soc_reset) begin
                if (r_counter < RESET_LIMIT) begin
                    r_counter <= r_counter + 8'd1;
                end else begin
                    r_soc_reset <= 1'b0;
                    r_led       <= 1'b1;
                end
            end
            if (w_rx_valid) begin
                case (w_rx_data[7:0])
                    CMD_CLK_OFF: r_clk_enable <= 1'b0;
                    CMD_CLK_ON:  r_clk_enable <= 1'b1;
                    CMD_RST_ON: begin
                        r_soc_reset <= 1'b1;
                        r_led       <= 1'b0;
                        r_counter   <= '0;
                    end
                    CMD_RST_OFF: begin
                        r_soc_reset <= 1'b0;
                        r_led       <= 1'b1;
                    end
                    CMD_TX_SOC:  r_output_sel <= 1'b0;
                    CMD_TX_CTRL: r_output_sel <= 1'b1;
                    CMD_RX_EN:   r_input_sel  <= 1'b0;
                    CMD_RX_DIS:  r_input_sel  <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Integrated clock-gate: the enable can only change while clk27 is low,
    // so the AND below never produces a shortened high phase.
    always_latch begin
        if (!clk27) r_clk_en_lat <= r_clk_enable;
    end

    assign soc_clk   = clk27 & r_clk_en_lat;
    assign soc_reset = r_soc_reset;
    assign led_n1    = r_led;
    assign serial_tx = r_output_sel ? w_uart_tx : soc_tx;
    assign soc_rx    = r_input_sel ? 1'b1 : serial_rx;

endmodule

// File: tb/tb_soc_uart_controller.sv
module tb_soc_uart_controller;

    localparam int CLK_HZ       = 160;
    localparam int BIT_RATE     = 10;
    localparam int RESET_CYCLES = 200;
    localparam int CPB          = 16;   // 160 / 10

    logic clk27     = 1'b0;
    logic reset     = 1'b1;
    logic serial_rx = 1'b1;
    logic soc_tx    = 1'b1;
    logic serial_tx, led_n1, soc_rx, soc_clk, soc_reset;

    always #5 clk27 = ~clk27;

    soc_uart_controller #(
        .CLK_HZ       (CLK_HZ),
        .BIT_RATE     (BIT_RATE),
        .PAYLOAD_BITS (8),
        .RESET_CYCLES (RESET_CYCLES)
    ) dut (
        .clk27     (clk27),
        .reset     (reset),
        .serial_rx (serial_rx),
        .serial_tx (serial_tx),
        .led_n1    (led_n1),
        .soc_tx    (soc_tx),
        .soc_rx    (soc_rx),
        .soc_clk   (soc_clk),
        .soc_reset (soc_reset)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         mon_en      = 1'b0;
    bit         tb_out_sel  = 1'b0;
    int         clk_edges   = 0;
    logic [7:0] mon_byte;

    always @(posedge soc_clk) clk_edges++;

    // Decodes frames appearing on serial_tx (soc_tx is held high meanwhile).
    initial begin
        forever begin
            @(negedge clk27);
            if (mon_en && serial_tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk27);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk27);
                    mon_byte[i] = serial_tx;
                end
                repeat (CPB) @(negedge clk27);
                got_q.push_back(mon_byte);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk27);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        serial_rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            serial_rx = b[i];
            cycles(CPB);
        end
        serial_rx = stop_bit;
        cycles(CPB);
        serial_rx = 1'b1;
    endtask

    task automatic apply(input logic [7:0] b);
        if (b == 8'h04) tb_out_sel = 1'b0;
        else if (b == 8'h05) tb_out_sel = 1'b1;
        if (tb_out_sel && mon_en) exp_q.push_back(b);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        send_frame(b, 1'b1);
        apply(b);
    endtask

    task automatic check_echo(input string tag);
        logic [7:0] e, g;
        cycles(12 * CPB);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check(tag, g, e);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic measure_pulse(output int len, output int led_bad);
        int n = 0;
        len = 0;
        led_bad = 0;
        @(negedge clk27);
        while (soc_reset !== 1'b1 && n < 40 * CPB) begin
            @(negedge clk27);
            n++;
        end
        while (soc_reset === 1'b1 && len < 1000) begin
            if (led_n1 !== 1'b0) led_bad++;
            len++;
            @(negedge clk27);
        end
    endtask

    task automatic count_clk(input string tag, input int n, input int expect_edges);
        int e0;
        e0 = clk_edges;
        cycles(n);
        check(tag, clk_edges - e0, expect_edges);
    endtask

    initial begin
        int len, bad, zeros, mism;

        // ---- reset state ----
        cycles(5);
        reset = 1'b0;
        cycles(3);
        check("rst_soc_reset", soc_reset, 0);
        check("rst_led_n1", led_n1, 1);
        check("rst_serial_tx", serial_tx, 1);
        check("rst_soc_rx", soc_rx, 1);
        soc_tx = 1'b0;  #1 check("rst_tx_follow_lo", serial_tx, 0);
        soc_tx = 1'b1;  #1 check("rst_tx_follow_hi", serial_tx, 1);
        serial_rx = 1'b0; #1 check("rst_rx_follow_lo", soc_rx, 0);
        serial_rx = 1'b1; #1 check("rst_rx_follow_hi", soc_rx, 1);
        cycles(2 * CPB);
        @(posedge clk27); #1 check("rst_soc_clk_hi", soc_clk, 1);
        @(negedge clk27); #1 check("rst_soc_clk_lo", soc_clk, 0);
        count_clk("rst_clk_edges", 10, 10);

        // ---- echo through controller TX ----
        mon_en = 1'b1;
        send_cmd(8'h05); check_echo("echo_05");
        send_cmd(8'h41); check_echo("echo_41");
        send_cmd(8'h04); check_echo("echo_04");
        mon_en = 1'b0;
        soc_tx = 1'b0; #1 check("sel_soc_tx_lo", serial_tx, 0);
        soc_tx = 1'b1; #1 check("sel_soc_tx_hi", serial_tx, 1);
        cycles(2);
        mon_en = 1'b1;

        // ---- SoC reset pulse ----
        fork
            send_frame(8'h02, 1'b1);
            measure_pulse(len, bad);
        join
        apply(8'h02);
        check("pulse_len", len, RESET_CYCLES + 1);
        check("pulse_led", bad, 0);
        check("pulse_rel_reset", soc_reset, 0);
        check("pulse_rel_led", led_n1, 1);
        check_echo("echo_02");

        fork
            begin
                send_frame(8'h02, 1'b1);
                cycles(10);
                send_frame(8'h02, 1'b1);
            end
            measure_pulse(len, bad);
        join
        check("pulse_restart_len", len, 10 * CPB + 10 + RESET_CYCLES + 1);
        check("pulse_restart_led", bad, 0);
        check_echo("echo_restart");

        fork
            begin
                send_frame(8'h02, 1'b1);
                cycles(10);
                send_frame(8'h03, 1'b1);
            end
            measure_pulse(len, bad);
        join
        check("pulse_abort_len", len, 10 * CPB + 10);
        check("pulse_abort_led", led_n1, 1);
        check_echo("echo_abort");

        // ---- clock gating ----
        send_cmd(8'h00);
        cycles(2);
        count_clk("clk_off_edges", 40, 0);
        @(posedge clk27); #1 check("clk_off_level", soc_clk, 0);
        @(negedge clk27);
        send_cmd(8'h01);
        cycles(2);
        count_clk("clk_on_edges", 20, 20);
        @(posedge clk27); #1 check("clk_on_level", soc_clk, 1);
        @(negedge clk27);
        check_echo("echo_clk");

        // ---- input steering ----
        send_cmd(8'h07);
        cycles(12 * CPB);
        zeros = 0;
        fork
            send_frame(8'h55, 1'b1);
            repeat (10 * CPB) begin
                @(negedge clk27);
                #1 if (soc_rx !== 1'b1) zeros++;
            end
        join
        check("rx_dis_held", zeros, 0);
        cycles(12 * CPB);
        send_cmd(8'h06);
        cycles(12 * CPB);
        zeros = 0;
        mism = 0;
        fork
            send_frame(8'h55, 1'b1);
            repeat (10 * CPB) begin
                @(negedge clk27);
                #1;
                if (soc_rx !== serial_rx) mism++;
                if (soc_rx === 1'b0) zeros++;
            end
        join
        check("rx_en_follow", mism, 0);
        check("rx_en_active", zeros > 0, 1);
        check_echo("echo_rx");

        // ---- framing error ----
        send_cmd(8'h05); check_echo("echo_05b");
        send_frame(8'h00, 1'b0);
        cycles(4);
        count_clk("frame_err_clk", 20, 20);
        check_echo("echo_frame_err");
        send_cmd(8'h41); check_echo("echo_41b");

        // ---- controller reset mid-frame ----
        send_cmd(8'h07); check_echo("echo_07");
        send_cmd(8'h00); check_echo("echo_00");
        mon_en = 1'b0;
        send_frame(8'h02, 1'b1);
        cycles(2);
        check("pre_rst_soc_reset", soc_reset, 1);
        serial_rx = 1'b0;
        cycles(3 * CPB);
        reset = 1'b1;
        serial_rx = 1'b1;
        cycles(3);
        reset = 1'b0;
        tb_out_sel = 1'b0;
        cycles(2);
        check("mid_rst_soc_reset", soc_reset, 0);
        check("mid_rst_led_n1", led_n1, 1);
        check("mid_rst_serial_tx", serial_tx, 1);
        soc_tx = 1'b0; #1 check("mid_rst_tx_follow", serial_tx, 0);
        soc_tx = 1'b1;
        serial_rx = 1'b0; #1 check("mid_rst_rx_follow", soc_rx, 0);
        serial_rx = 1'b1;
        count_clk("mid_rst_clk", 10, 10);
        cycles(12 * CPB);
        got_q.delete();
        exp_q.delete();
        mon_en = 1'b1;
        send_cmd(8'h05); check_echo("echo_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
